// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv
// Purpose  : RV32M multiply/divide unit for the EX stage. Divisions use a
//            32-iteration restoring radix-2 divider. Multiplications use a
//            32-iteration shift-add datapath that shares the divider's
//            registers, or a single-cycle multiplier when
//            MULDIV_FAST_MUL_EN is defined.
//            Divide by zero and signed overflow (0x80000000 / -1) finish one
//            cycle after acceptance in both configurations.
// Ports    : clk        core clock, rising edge
//            rst        synchronous active-high reset
//            start      EX-stage instruction is an M-extension op
//            md_op      0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//            src1/src2  forwarded rs1 / rs2 operands
//            flush      pipeline flush, aborts the current operation
//            md_stall   stall request to PC, IF/ID and ID/EX registers
//            md_done    one-cycle pulse, md_result valid
//            md_result  product / quotient / remainder word
// Config   : MULDIV_FAST_MUL_EN - single-cycle 33x33 signed multiplier
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        flush,
    output logic        md_stall,
    output logic        md_done,
    output logic [31:0] md_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN  = 32'h8000_0000;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] rem_q;      // divider partial remainder / multiplier high word
    logic [31:0] quo_q;      // dividend->quotient / multiplier->low word
    logic [31:0] dvs_q;      // divisor / multiplicand magnitude
    logic [2:0]  op_q;
    logic        qneg_q;     // negate quotient or product
    logic        rneg_q;     // negate remainder
    logic        done_q;
    logic [31:0] result_q;

    // ------------------------------------------------------------------
    // Input decode at acceptance
    // ------------------------------------------------------------------
    logic        in_is_div;
    logic        in_is_rem;
    logic        in_div_signed;
    logic        in_a_signed;
    logic        in_b_signed;
    logic        s1_neg;
    logic        s2_neg;
    logic [31:0] mag1;
    logic [31:0] mag2;
    logic        div_by_zero;
    logic        div_ovf;
    logic [31:0] special_result;
    logic        accept;

    assign in_is_div     = md_op[2];
    assign in_is_rem     = md_op[1];
    assign in_div_signed = md_op[2] & ~md_op[0];
    // MULH and MULHSU treat rs1 as signed; only MULH treats rs2 as signed.
    // MUL's low word is sign-agnostic, so it runs unsigned.
    assign in_a_signed   = in_is_div ? in_div_signed
                                     : ((md_op[1:0] == 2'd1) || (md_op[1:0] == 2'd2));
    assign in_b_signed   = in_is_div ? in_div_signed : (md_op[1:0] == 2'd1);
    assign s1_neg        = in_a_signed & src1[31];
    assign s2_neg        = in_b_signed & src2[31];
    assign mag1          = s1_neg ? (~src1 + 32'd1) : src1;
    assign mag2          = s2_neg ? (~src2 + 32'd1) : src2;
    assign div_by_zero   = in_is_div & (src2 == 32'd0);
    assign div_ovf       = in_div_signed & (src1 == INT_MIN) & (src2 == ALL_ONES);
    assign special_result = div_by_zero ? (in_is_rem ? src1 : ALL_ONES)
                                        : (in_is_rem ? 32'd0 : INT_MIN);

    assign accept   = start & (state_q != CALC) & ~flush;
    assign md_stall = (state_q == CALC) | accept;
    assign md_done  = done_q;
    assign md_result = result_q;

    // ------------------------------------------------------------------
    // Optional single-cycle multiplier
    // ------------------------------------------------------------------
    logic        fast_hit;
    logic [31:0] fast_result;

`ifdef MULDIV_FAST_MUL_EN
    logic signed [65:0] fast_a;
    logic signed [65:0] fast_b;
    logic signed [65:0] fast_prod;
    logic               unused_fast;

    // Operands are the 33-bit signed forms of rs1/rs2, extended to 66 bits.
    assign fast_a      = {{34{in_a_signed & src1[31]}}, src1};
    assign fast_b      = {{34{in_b_signed & src2[31]}}, src2};
    assign fast_prod   = fast_a * fast_b;
    assign fast_hit    = ~in_is_div;
    assign fast_result = (md_op[1:0] == 2'd0) ? fast_prod[31:0] : fast_prod[63:32];
    assign unused_fast = ^fast_prod[65:64];
`else
    assign fast_hit    = 1'b0;
    assign fast_result = 32'd0;
`endif

    // ------------------------------------------------------------------
    // One iteration of the shared divide / multiply datapath
    // ------------------------------------------------------------------
    logic [32:0] div_shift;
    logic [33:0] div_trial;
    logic [32:0] mul_sum;
    logic [31:0] rem_d;
    logic [31:0] quo_d;
    logic        unused_step;

    assign div_shift   = {rem_q, quo_q[31]};
    assign div_trial   = {1'b0, div_shift} - {2'b00, dvs_q};
    assign mul_sum     = {1'b0, rem_q} + (quo_q[0] ? {1'b0, dvs_q} : 33'd0);
    // The trial difference never exceeds 32 bits when non-negative.
    assign unused_step = div_trial[32];

    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        if (op_q[2]) begin
            // Restoring step: keep the subtraction only if it did not borrow.
            if (div_trial[33]) begin
                rem_d = div_shift[31:0];
                quo_d = {quo_q[30:0], 1'b0};
            end else begin
                rem_d = div_trial[31:0];
                quo_d = {quo_q[30:0], 1'b1};
            end
        end else begin
            // Shift-add step: {carry, hi, lo} shifts right by one.
            rem_d = mul_sum[32:1];
            quo_d = {mul_sum[0], quo_q[31:1]};
        end
    end

    // ------------------------------------------------------------------
    // Sign correction and word select for the final iteration
    // ------------------------------------------------------------------
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [63:0] prod_mag;
    logic [63:0] prod_fix;
    logic [31:0] calc_result;

    assign quo_fix  = qneg_q ? (~quo_d + 32'd1) : quo_d;
    assign rem_fix  = rneg_q ? (~rem_d + 32'd1) : rem_d;
    assign prod_mag = {rem_d, quo_d};
    assign prod_fix = qneg_q ? (~prod_mag + 64'd1) : prod_mag;

    always_comb begin
        calc_result = 32'd0;
        if (op_q[2]) begin
            calc_result = op_q[1] ? rem_fix : quo_fix;
        end else if (op_q[1:0] == 2'd0) begin
            calc_result = prod_fix[31:0];
        end else begin
            calc_result = prod_fix[63:32];
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            rem_q    <= 32'd0;
            quo_q    <= 32'd0;
            dvs_q    <= 32'd0;
            op_q     <= 3'd0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 32'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                CALC: begin
                    // start is ignored here; flush abandons without a result.
                    if (flush) begin
                        state_q <= IDLE;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            result_q <= calc_result;
                        end
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new operation.
                    if (accept) begin
                        op_q   <= md_op;
                        qneg_q <= s1_neg ^ s2_neg;
                        rneg_q <= s1_neg;
                        if (div_by_zero || div_ovf) begin
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            result_q <= special_result;
                        end else if (fast_hit) begin
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            result_q <= fast_result;
                        end else begin
                            state_q <= CALC;
                            cnt_q   <= 5'd0;
                            rem_q   <= 32'd0;
                            quo_q   <= mag1;
                            dvs_q   <= mag2;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_muldiv
// Purpose  : directed self-checking bench for ex_muldiv
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        flush;
    logic        md_stall;
    logic        md_done;
    logic [31:0] md_result;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

    ex_muldiv dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .md_op     (md_op),
        .src1      (src1),
        .src2      (src2),
        .flush     (flush),
        .md_stall  (md_stall),
        .md_done   (md_done),
        .md_result (md_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc holds the index of the current cycle; it steps at every rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a falling edge: presents an op for one cycle, checks the stall
    // request in that cycle and returns its cycle index.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag, output int t0);
        start = 1'b1;
        md_op = op;
        src1  = a;
        src2  = b;
        #1;
        t0 = cyc;
        chk({tag, " stall@T"}, {31'd0, md_stall}, 32'd1);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Waits at falling edges for md_done, up to limit cycles.
    task automatic wait_done(input int limit, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (md_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] exp, input string tag);
        int   t0;
        logic seen;
        @(negedge clk);
        issue(op, a, b, tag, t0);
        if (lat > 1) begin
            @(negedge clk);
            chk({tag, " stall@T+1"}, {31'd0, md_stall}, 32'd1);
        end
        wait_done(40, seen);
        chk({tag, " done seen"}, {31'd0, seen}, 32'd1);
        chk({tag, " latency"}, cyc - t0, lat);
        chk({tag, " result"}, md_result, exp);
        chk({tag, " stall@done"}, {31'd0, md_stall}, 32'd0);
        @(negedge clk);
        chk({tag, " done pulse"}, {31'd0, md_done}, 32'd0);
        chk({tag, " hold"}, md_result, exp);
    endtask

    initial begin
        int   t0;
        logic seen;

        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        md_op = 3'd0;
        src1  = 32'd0;
        src2  = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst md_done", {31'd0, md_done}, 32'd0);
        chk("rst md_result", md_result, 32'd0);
        chk("rst md_stall", {31'd0, md_stall}, 32'd0);
        rst = 1'b0;

        // Division, sign correction
        run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, "DIV -7/2");
        run_op(OP_REM,  32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, "REM -7/2");
        run_op(OP_DIV,  32'd100, 32'hFFFF_FFF9, 33, 32'hFFFF_FFF2, "DIV 100/-7");
        run_op(OP_REM,  32'd100, 32'hFFFF_FFF9, 33, 32'd2, "REM 100/-7");
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd16, 33, 32'h0FFF_FFFF, "DIVU big/16");
        run_op(OP_REMU, 32'hFFFF_FFFF, 32'd16, 33, 32'd15, "REMU big/16");

        // Divide by zero and signed overflow
        run_op(OP_DIVU, 32'd100, 32'd0, 1, 32'hFFFF_FFFF, "DIVU 100/0");
        run_op(OP_REMU, 32'd100, 32'd0, 1, 32'd100, "REMU 100/0");
        run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, "DIV ovf");
        run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, "REM ovf");

        // Multiplication
        run_op(OP_MULH,   32'h8000_0000, 32'h8000_0000, MUL_LAT, 32'h4000_0000, "MULH");
        run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 32'hFFFF_FFFF, "MULHSU");
        run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 32'hFFFF_FFFE, "MULHU");
        run_op(OP_MUL,    32'd7, 32'hFFFF_FFFD, MUL_LAT, 32'hFFFF_FFEB, "MUL 7*-3");
        run_op(OP_MULH,   32'd7, 32'hFFFF_FFFD, MUL_LAT, 32'hFFFF_FFFF, "MULH 7*-3");

        // Flush at T+10 of a DIVU: md_result keeps 0xFFFFFFFF from MULH above
        @(negedge clk);
        issue(OP_DIVU, 32'd1000, 32'd7, "flush", t0);
        do @(negedge clk); while (cyc < t0 + 10);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush T+11 stall", {31'd0, md_stall}, 32'd0);
        chk("flush T+11 done", {31'd0, md_done}, 32'd0);
        chk("flush T+11 result", md_result, 32'hFFFF_FFFF);
        wait_done(40, seen);
        chk("flush no done", {31'd0, seen}, 32'd0);

        // Flush has priority over start
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        md_op = OP_DIVU;
        src1  = 32'd5;
        src2  = 32'd0;
        #1;
        chk("flush+start stall", {31'd0, md_stall}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        wait_done(5, seen);
        chk("flush+start no done", {31'd0, seen}, 32'd0);

        // Reset at T+5 of a DIV
        @(negedge clk);
        issue(OP_DIV, 32'd50, 32'd5, "rst", t0);
        do @(negedge clk); while (cyc < t0 + 5);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst CALC done", {31'd0, md_done}, 32'd0);
        chk("rst CALC result", md_result, 32'd0);
        chk("rst CALC stall", {31'd0, md_stall}, 32'd0);
        wait_done(40, seen);
        chk("rst CALC no done", {31'd0, seen}, 32'd0);

        // Back-to-back: DIVU 20/4, then DIVU 10/3 issued in its DONE cycle.
        // A div-by-zero start while in CALC must be ignored.
        @(negedge clk);
        issue(OP_DIVU, 32'd20, 32'd4, "b2b first", t0);
        wait_done(40, seen);
        chk("b2b first latency", cyc - t0, 32'd33);
        chk("b2b first result", md_result, 32'd5);
        issue(OP_DIVU, 32'd10, 32'd3, "b2b second", t0);
        do @(negedge clk); while (cyc < t0 + 5);
        issue(OP_DIVU, 32'd99, 32'd0, "ignored start", seen);
        wait_done(40, seen);
        chk("b2b second seen", {31'd0, seen}, 32'd1);
        chk("b2b second latency", cyc - t0, 32'd33);
        chk("b2b second result", md_result, 32'd3);
        repeat (3) @(negedge clk);
        chk("b2b hold", md_result, 32'h0000_0003);
        chk("b2b hold done", {31'd0, md_done}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single core clock; all state updates occur on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: the EX-stage instruction held in the ID/EX register is an M-extension op.
REQ-004 SHALL have port md_op, input, 3 bits: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-005 SHALL have port src1, input, 32 bits: forwarded rs1 operand.
REQ-006 SHALL have port src2, input, 32 bits: forwarded rs2 operand.
REQ-007 SHALL have port flush, input, 1 bit: pipeline flush; abort the current operation.
REQ-008 SHALL have port md_stall, output, 1 bit: stall request to the PC, IF/ID and ID/EX registers.
REQ-009 SHALL have port md_done, output, 1 bit: one-cycle pulse marking md_result valid.
REQ-010 SHALL have port md_result, output, 32 bits: selected product/quotient/remainder word.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, DONE.
REQ-012 SHALL accept start only in IDLE or DONE, latching md_op, src1, src2 and the signs.
REQ-013 SHALL ignore start while in CALC.
REQ-014 SHALL drive md_stall = (state==CALC) | (start & state!=CALC & ~flush), combinationally.
REQ-015 SHALL, for a division accepted at cycle T, run 32 restoring radix-2 iterations in CALC (T+1..T+32), enter DONE at T+33, and pulse md_done for that one cycle.
REQ-016 SHALL perform signed ops on magnitudes, then correct the signs: quotient negative iff the operand signs differ; remainder takes the sign of src1.
REQ-017 SHALL handle divide by zero by going IDLE->DONE at T+1: DIV/DIVU quotient 0xFFFFFFFF, REM/REMU remainder = src1.
REQ-018 SHALL handle signed overflow (DIV/REM with src1 0x80000000, src2 0xFFFFFFFF) by going to DONE at T+1 with quotient 0x80000000 and remainder 0.
REQ-019 SHALL return a MUL-class result as the low word (MUL) or high word (MULH*) of the 64-bit product, with signedness as defined by RV32M.
REQ-020 SHALL hold md_result stable from DONE until the next accepted start.
REQ-021 SHALL go DONE->IDLE on the next cycle unless a new start is accepted, in which case the next state is CALC or DONE per the op.
REQ-022 SHALL, on flush in any state, return to IDLE on the next edge with md_done=0 and md_result unchanged.
REQ-023 SHALL give flush priority over start.

Reset
REQ-024 SHALL, on rst, force the state to IDLE, md_done=0, md_result=0, and clear the iteration counter and working registers.
REQ-025 SHALL, on rst during CALC, abandon the operation and produce no md_done.

Configuration
REQ-026 SHALL, with MULDIV_FAST_MUL_EN defined, compute MUL-class ops with a single-cycle 33x33 signed multiplier: IDLE->DONE, md_done at T+1.
REQ-027 SHALL, without MULDIV_FAST_MUL_EN, compute MUL-class ops by 32-iteration shift-add in CALC, with md_done at T+33, the same as division.
REQ-028 SHALL leave division latency and all special cases identical in both configurations.

Verification
REQ-029 SHALL cover: DIV src1=-7, src2=2 -> md_done at T+33, result 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF.
REQ-030 SHALL cover: DIVU src1=100, src2=0 -> md_done at T+1, result 0xFFFFFFFF; REMU with the same operands -> 100.
REQ-031 SHALL cover: DIV 0x80000000 / 0xFFFFFFFF -> md_done at T+1, result 0x80000000, md_stall high only in cycle T.
REQ-032 SHALL cover: MULH 0x80000000 * 0x80000000 -> 0x40000000 and MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF, at T+1 with the macro and T+33 without.
REQ-033 SHALL cover: flush at T+10 of a DIVU -> IDLE at T+11, no md_done, md_stall low, md_result keeps its old value.
REQ-034 SHALL cover: rst at T+5 of a DIV, then a back-to-back start in the DONE cycle of a new DIVU 10/3 -> the second op accepted, md_result 3 at its DONE, then 0x00000003 held.
